// File: rtl/input_entry_ctrl.sv
// input_entry_ctrl: sequencing controller for the 4-digit decimal entry datapath.
//   Edits four BCD digits in place under a cursor (inc/dec/next with auto-repeat
//   on inc/dec). On enter, converts the BCD value to binary over 4 cycles and
//   presents it on an MMIO read port with a valid/ack handshake.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   btn_inc    in   debounced level, increment digit at cursor
//   btn_dec    in   debounced level, decrement digit at cursor
//   btn_next   in   debounced level, move cursor toward LSD (wraps 0 -> 3)
//   btn_enter  in   debounced level, commit value
//   data_ack   in   single-cycle pulse, CPU has read data
//   digits     out  [15:12]=digit3 (MSD) .. [3:0]=digit0
//   cursor     out  index of digit under edit
//   busy       out  high in CONV or HOLD
//   data_valid out  data valid and unread
//   data       out  binary value of committed digits (0..9999)
module input_entry_ctrl #(
  parameter logic [23:0] REPEAT_DLY  = 24'd5_000_000,
  parameter logic [23:0] REPEAT_RATE = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_next,
  input  logic        btn_enter,
  input  logic        data_ack,
  output logic [15:0] digits,
  output logic [1:0]  cursor,
  output logic        busy,
  output logic        data_valid,
  output logic [13:0] data
);

  typedef enum logic [1:0] {StEdit, StConv, StHold} state_e;

  state_e      r_state;
  logic [15:0] r_digits;
  logic [1:0]  r_cursor;
  logic        r_busy;
  logic        r_data_valid;
  logic [13:0] r_data;
  logic [13:0] r_acc;
  logic [1:0]  r_k;
  logic        r_inc_prev, r_dec_prev, r_next_prev, r_enter_prev;
  logic [23:0] r_inc_cnt, r_dec_cnt;
  logic        r_inc_rpt, r_dec_rpt;

  logic        w_inc_evt, w_dec_evt, w_next_evt, w_enter_evt;
  logic        w_inc_fire, w_dec_fire, w_inc_step, w_dec_step;
  logic        w_edit_active;
  logic [3:0]  w_cur, w_conv_digit;
  logic [13:0] w_acc_next;
  logic [23:0] w_inc_cnt_d, w_dec_cnt_d;
  logic        w_inc_rpt_d, w_dec_rpt_d;

  assign w_inc_evt   = btn_inc & ~r_inc_prev;
  assign w_dec_evt   = btn_dec & ~r_dec_prev;
  assign w_next_evt  = btn_next & ~r_next_prev;
  assign w_enter_evt = btn_enter & ~r_enter_prev;

  // Editing is live only in EDIT and only when enter is not pre-empting this cycle.
  assign w_edit_active = (r_state == StEdit) && !w_enter_evt;

  // Counter holds cycles since the press edge (or since the last repeat step).
  assign w_inc_fire = btn_inc && (r_inc_cnt != 24'd0) &&
                      (r_inc_rpt ? (r_inc_cnt == REPEAT_RATE) : (r_inc_cnt == REPEAT_DLY));
  assign w_dec_fire = btn_dec && (r_dec_cnt != 24'd0) &&
                      (r_dec_rpt ? (r_dec_cnt == REPEAT_RATE) : (r_dec_cnt == REPEAT_DLY));
  assign w_inc_step = w_inc_evt | w_inc_fire;
  assign w_dec_step = w_dec_evt | w_dec_fire;

  assign w_cur        = r_digits[{r_cursor, 2'b00} +: 4];
  // digit[3-k] with 2-bit k is digit[~k].
  assign w_conv_digit = r_digits[{~r_k, 2'b00} +: 4];
  assign w_acc_next   = (r_acc << 3) + (r_acc << 1) + {10'd0, w_conv_digit};

  always_comb begin
    w_inc_cnt_d = 24'd0;
    w_inc_rpt_d = 1'b0;
    w_dec_cnt_d = 24'd0;
    w_dec_rpt_d = 1'b0;
    if (w_edit_active && btn_inc) begin
      if (w_inc_evt || w_inc_fire) begin
        w_inc_cnt_d = 24'd1;
        w_inc_rpt_d = w_inc_fire;
      end else if (r_inc_cnt != 24'd0) begin
        w_inc_cnt_d = r_inc_cnt + 24'd1;
        w_inc_rpt_d = r_inc_rpt;
      end
    end
    if (w_edit_active && btn_dec) begin
      if (w_dec_evt || w_dec_fire) begin
        w_dec_cnt_d = 24'd1;
        w_dec_rpt_d = w_dec_fire;
      end else if (r_dec_cnt != 24'd0) begin
        w_dec_cnt_d = r_dec_cnt + 24'd1;
        w_dec_rpt_d = r_dec_rpt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StEdit;
      r_digits     <= 16'd0;
      r_cursor     <= 2'd3;
      r_busy       <= 1'b0;
      r_data_valid <= 1'b0;
      r_data       <= 14'd0;
      r_acc        <= 14'd0;
      r_k          <= 2'd0;
      r_inc_prev   <= 1'b0;
      r_dec_prev   <= 1'b0;
      r_next_prev  <= 1'b0;
      r_enter_prev <= 1'b0;
      r_inc_cnt    <= 24'd0;
      r_dec_cnt    <= 24'd0;
      r_inc_rpt    <= 1'b0;
      r_dec_rpt    <= 1'b0;
    end else begin
      r_inc_prev   <= btn_inc;
      r_dec_prev   <= btn_dec;
      r_next_prev  <= btn_next;
      r_enter_prev <= btn_enter;
      r_inc_cnt    <= w_inc_cnt_d;
      r_dec_cnt    <= w_dec_cnt_d;
      r_inc_rpt    <= w_inc_rpt_d;
      r_dec_rpt    <= w_dec_rpt_d;

      unique case (r_state)
        StEdit: begin
          if (w_enter_evt) begin
            r_state <= StConv;
            r_busy  <= 1'b1;
            r_acc   <= 14'd0;
            r_k     <= 2'd0;
          end else begin
            if (w_inc_step && !w_dec_step && (w_cur != 4'd9)) begin
              r_digits[{r_cursor, 2'b00} +: 4] <= w_cur + 4'd1;
            end else if (w_dec_step && !w_inc_step && (w_cur != 4'd0)) begin
              r_digits[{r_cursor, 2'b00} +: 4] <= w_cur - 4'd1;
            end
            if (w_next_evt) begin
              r_cursor <= r_cursor - 2'd1;  // 0 wraps to 3
            end
          end
        end
        StConv: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_data       <= w_acc_next;
            r_data_valid <= 1'b1;
            r_state      <= StHold;
          end
        end
        StHold: begin
          if (data_ack) begin
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= StEdit;
          end
        end
        default: begin
          r_state <= StEdit;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign digits     = r_digits;
  assign cursor     = r_cursor;
  assign busy       = r_busy;
  assign data_valid = r_data_valid;
  assign data       = r_data;

endmodule

// File: tb/tb_input_entry_ctrl.sv
module tb_input_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;  // {enter, next, dec, inc}
  logic        data_ack;
  logic [15:0] digits;
  logic [1:0]  cursor;
  logic        busy;
  logic        data_valid;
  logic [13:0] data;

  int n_chk  = 0;
  int n_pass = 0;

  localparam int Inc = 0;
  localparam int Dec = 1;
  localparam int Nxt = 2;
  localparam int Ent = 3;

  always #5 clk = ~clk;

  input_entry_ctrl #(
    .REPEAT_DLY (24'd10),
    .REPEAT_RATE(24'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_inc   (btn[0]),
    .btn_dec   (btn[1]),
    .btn_next  (btn[2]),
    .btn_enter (btn[3]),
    .data_ack  (data_ack),
    .digits    (digits),
    .cursor    (cursor),
    .busy      (busy),
    .data_valid(data_valid),
    .data      (data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic press(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      btn[idx] = 1'b1;
      step();
      btn[idx] = 1'b0;
      step();
    end
  endtask

  task automatic ack();
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    btn      = 4'b0;
    data_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_cursor", 32'(cursor), 32'd3);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Basic editing
    press(Inc, 3);
    press(Nxt, 1);
    press(Inc, 2);
    press(Nxt, 1);
    press(Dec, 1);
    chk("edit_digits", 32'(digits), 32'h3200);
    chk("edit_cursor", 32'(cursor), 32'd1);

    // Build 1234
    press(Inc, 3);
    press(Nxt, 1);
    press(Inc, 4);
    press(Nxt, 1);
    chk("wrap_cursor", 32'(cursor), 32'd3);
    press(Dec, 2);
    press(Nxt, 1);
    chk("set_1234", 32'(digits), 32'h1234);
    chk("set_cursor", 32'(cursor), 32'd2);

    // Enter -> 4 CONV cycles -> HOLD
    btn[Ent] = 1'b1;
    step();
    btn[Ent] = 1'b0;
    chk("conv1_busy", 32'(busy), 32'd1);
    chk("conv1_valid", 32'(data_valid), 32'd0);
    btn[Inc] = 1'b1;  // ignored during CONV
    step();
    chk("conv2_valid", 32'(data_valid), 32'd0);
    btn[Inc] = 1'b0;
    step();
    chk("conv3_valid", 32'(data_valid), 32'd0);
    step();
    chk("conv4_valid", 32'(data_valid), 32'd0);
    chk("conv4_busy", 32'(busy), 32'd1);
    step();
    chk("hold_valid", 32'(data_valid), 32'd1);
    chk("hold_data", 32'(data), 32'd1234);
    chk("hold_busy", 32'(busy), 32'd1);

    // Button events in HOLD are ignored
    press(Inc, 1);
    press(Nxt, 1);
    press(Ent, 1);
    chk("hold_ign_digits", 32'(digits), 32'h1234);
    chk("hold_ign_cursor", 32'(cursor), 32'd2);
    chk("hold_ign_data", 32'(data), 32'd1234);
    chk("hold_ign_valid", 32'(data_valid), 32'd1);

    ack();
    chk("ack_valid", 32'(data_valid), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
    chk("ack_digits", 32'(digits), 32'h1234);
    chk("ack_data", 32'(data), 32'd1234);

    // 9999, with saturation at 9
    press(Inc, 7);
    press(Nxt, 1);
    press(Inc, 6);
    press(Nxt, 1);
    press(Inc, 5);
    press(Nxt, 1);
    press(Inc, 9);
    chk("sat9_digits", 32'(digits), 32'h9999);
    chk("sat9_cursor", 32'(cursor), 32'd3);
    press(Ent, 1);
    step();
    step();
    step();
    chk("c9999_valid", 32'(data_valid), 32'd1);
    chk("c9999_data", 32'(data), 32'd9999);
    ack();

    // 0000
    for (int d = 0; d < 4; d++) begin
      press(Dec, 9);
      press(Nxt, 1);
    end
    chk("zero_digits", 32'(digits), 32'h0000);
    chk("zero_cursor", 32'(cursor), 32'd3);
    press(Ent, 1);
    step();
    step();
    step();
    chk("c0_valid", 32'(data_valid), 32'd1);
    chk("c0_data", 32'(data), 32'd0);
    ack();
    chk("c0_ack_valid", 32'(data_valid), 32'd0);

    // Auto-repeat: 30 cycles held -> edge + steps at +10,+14,+18,+22,+26
    btn[Inc] = 1'b1;
    for (int i = 0; i < 30; i++) step();
    btn[Inc] = 1'b0;
    step();
    chk("repeat_digits", 32'(digits), 32'h6000);
    step();
    step();
    chk("repeat_release", 32'(digits), 32'h6000);

    // inc and dec rising together -> no change
    btn[Inc] = 1'b1;
    btn[Dec] = 1'b1;
    step();
    btn[Inc] = 1'b0;
    btn[Dec] = 1'b0;
    step();
    chk("incdec_same", 32'(digits), 32'h6000);
    press(Dec, 1);
    chk("dec_works", 32'(digits), 32'h5000);

    // Reset in CONV cycle 2
    btn[Ent] = 1'b1;
    step();
    btn[Ent] = 1'b0;
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_digits", 32'(digits), 32'h0);
    chk("abort_cursor", 32'(cursor), 32'd3);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(data_valid), 32'd0);
    chk("abort_data", 32'(data), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_valid", 32'(data_valid), 32'd0);
    end
    chk("abort_data_end", 32'(data), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/input_entry_ctrl.md
Name: input_entry_ctrl

Overview:
- Sequencing controller for the board's 4-digit decimal entry datapath.
- Takes debounced button levels and edits four BCD digits in place, under a cursor: increment, decrement, move cursor.
- On ENTER, converts the BCD value to binary over several cycles and presents it to the CPU's MMIO read port with a valid/ack handshake.
- Sits between the debouncers and the RV32 bus slave.

Parameters:
REPEAT_DLY, 24'd5_000_000, cycles inc/dec must be held before auto-repeat starts
REPEAT_RATE, 24'd1_000_000, cycles between auto-repeat steps once repeating

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
btn_inc  input  1  debounced level, increment digit at cursor
btn_dec  input  1  debounced level, decrement digit at cursor
btn_next  input  1  debounced level, advance cursor
btn_enter  input  1  debounced level, commit value
data_ack  input  1  CPU has read data; single-cycle pulse
digits  output  16  BCD digits, [15:12]=digit3 (MSD) .. [3:0]=digit0
cursor  output  2  index of digit under edit
busy  output  1  high in CONV or HOLD
data_valid  output  1  data is valid and unread
data  output  14  binary value of committed digits, 0..9999

Behaviour:
- Reset (rst=1 at a clk edge):
  - digits=0, cursor=3, data=0, data_valid=0, busy=0, state=EDIT.
  - Repeat counters and edge registers cleared; previous-level registers loaded with 0.
  - Reset mid-CONV or mid-HOLD aborts immediately. No partial data is exposed.
- Edge detection: each btn_* is registered once. An event is the cycle where level=1 and the registered level=0.
- FSM states: EDIT, CONV, HOLD.
- EDIT:
  - inc event: digit[cursor] += 1, saturating at 9.
  - dec event: digit[cursor] -= 1, saturating at 0.
  - inc and dec events or repeats in the same cycle: no change to digits.
  - next event: cursor = cursor-1, wrapping 0 -> 3. Processed independently of inc/dec; inc/dec in the same cycle apply to the old cursor.
  - enter event: go to CONV. Takes priority over inc/dec/next in the same cycle; those are dropped.
- Auto-repeat (EDIT only, inc and dec independently):
  - Hold counter starts at the event.
  - After REPEAT_DLY cycles of continuous hold, one step is applied, then one step every REPEAT_RATE cycles while held.
  - Release clears the counter. Steps saturate as above.
- CONV:
  - Exactly 4 cycles; step counter k=0..3, MSD first.
  - acc = acc*10 + digit[3-k], with acc cleared on CONV entry.
  - acc*10 is computed as (acc<<3)+(acc<<1) at 14 bits. No overflow is possible because the maximum is 9999.
  - Digits are frozen; all button events are ignored and edge registers keep updating.
  - After step k=3: data<=acc, data_valid<=1, go to HOLD.
- HOLD:
  - data and data_valid held stable; button events ignored.
  - data_ack: data_valid<=0 on the next edge, go to EDIT.
  - Digits and cursor retained on return to EDIT.
  - data_ack outside HOLD is ignored.
- Latency: with the enter event detected at edge E, the state is CONV from E, and data_valid is high from edge E+4 (visible in the cycle after the 4th CONV cycle).
- busy = (state != EDIT), registered and coincident with the state.
- data changes only on entry to HOLD; it keeps its last value after ack.

Test Plan:
- Reset, then cursor=3: 3 inc edges, next, 2 inc edges, next, 1 dec edge -> digits=16'h3200, cursor=1; dec at digit1=0 stays 0.
- Set digits to 1234, pulse enter -> busy=1 for 4 CONV cycles, data_valid=1 with data=14'd1234 at E+4; data_ack -> data_valid=0 next cycle, state EDIT, digits still 16'h1234.
- digits=9999 enter -> data=14'd9999; digits=0000 enter -> data=0. Inc at 9 stays 9; next from cursor 0 wraps to 3.
- REPEAT_DLY=10, REPEAT_RATE=4, hold btn_inc for 30 cycles from digit=0 -> 1 (edge) + steps at +10,+14,+18,+22,+26 = digit 6.
- During HOLD, press inc/next/enter -> digits, cursor and data unchanged. btn_inc and btn_dec rising in the same cycle -> digit unchanged.
- Assert rst in CONV cycle 2 -> next cycle all outputs at reset values, data_valid never asserts.
